load_mem_unit: RTL and testbench

- Memory-stage load engine of the kianv 5-stage pipeline; consumes the LoadOp_t produced at decode and carried down to M stage.
- Issues a word read on the data bus with a valid/ready handshake and holds the pipeline stall while the read is outstanding.
- Aligns and sign/zero-extends the returned word per LoadOp, then presents a one-cycle writeback result to the W stage.

---
 rtl/load_mem_unit.sv | 160 ++++++++++++++++
 tb/tb_load_mem_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_mem_unit.sv
// Memory-stage load engine: issues one word read per load, stalls while it is outstanding,
// then extends the selected byte/halfword/word into a one-cycle writeback. Optional macro: LOAD_MISALIGN_TRAP_EN.
package load_mem_pkg;
   typedef enum logic [2:0] {
      LOAD_OP_LB  = 3'd0,
      LOAD_OP_LH  = 3'd1,
      LOAD_OP_LW  = 3'd2,
      LOAD_OP_LBU = 3'd3,
      LOAD_OP_LHU = 3'd4
   } LoadOp_t;
endpackage

module load_mem_unit
   import load_mem_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  LoadOp_t         LoadOpM,
   input  logic [XLEN-1:0] addrM,
   input  logic [4:0]      rdM,
   input  logic            flush,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [XLEN-1:0] mem_addr,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            wb_fault,
   output logic            stall,
   output logic [1:0]      dbg_state
);

   // Handshakes: req accepted on a rising edge with req_valid && req_ready;
   // bus read completes on a rising edge with mem_valid && mem_ready.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);

   state_t           state;
   LoadOp_t          op_q;
   logic [1:0]       off_q;
   logic [4:0]       rd_q;
   logic             kill_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             timeout;
   logic             misaligned;
   logic [7:0]       sel_byte;
   logic [15:0]      sel_half;
   logic [XLEN-1:0]  load_val;

   assign dbg_state = state;
   assign cnt_inc   = cnt + 1'b1;
   assign timeout   = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);

`ifdef LOAD_MISALIGN_TRAP_EN
   assign misaligned = (((LoadOpM == LOAD_OP_LH) || (LoadOpM == LOAD_OP_LHU)) && addrM[0]) ||
                       ((LoadOpM == LOAD_OP_LW) && (addrM[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      sel_byte = mem_rdata[7:0];
      case (off_q)
         2'd1:    sel_byte = mem_rdata[15:8];
         2'd2:    sel_byte = mem_rdata[23:16];
         2'd3:    sel_byte = mem_rdata[31:24];
         default: sel_byte = mem_rdata[7:0];
      endcase
      sel_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (op_q)
         LOAD_OP_LB:  load_val = {{(XLEN-8){sel_byte[7]}}, sel_byte};
         LOAD_OP_LBU: load_val = {{(XLEN-8){1'b0}}, sel_byte};
         LOAD_OP_LH:  load_val = {{(XLEN-16){sel_half[15]}}, sel_half};
         LOAD_OP_LHU: load_val = {{(XLEN-16){1'b0}}, sel_half};
         default:     load_val = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         op_q      <= LOAD_OP_LB;
         off_q     <= 2'b00;
         rd_q      <= 5'd0;
         kill_q    <= 1'b0;
         cnt       <= '0;
         req_ready <= 1'b0;
         mem_valid <= 1'b0;
         mem_addr  <= '0;
         stall     <= 1'b0;
         wb_valid  <= 1'b0;
         wb_data   <= '0;
         wb_rd     <= 5'd0;
         wb_fault  <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  op_q      <= LoadOpM;
                  off_q     <= addrM[1:0];
                  rd_q      <= rdM;
                  mem_addr  <= {addrM[XLEN-1:2], 2'b00};
                  cnt       <= '0;
                  kill_q    <= 1'b0;
                  req_ready <= 1'b0;
                  if (misaligned) begin
                     state    <= S_DONE;
                     wb_valid <= 1'b1;
                     wb_fault <= 1'b1;
                     wb_data  <= '0;
                     wb_rd    <= rdM;
                  end else begin
                     state     <= S_BUS;
                     mem_valid <= 1'b1;
                     stall     <= 1'b1;
                  end
               end
            end
            S_BUS: begin
               if (flush) kill_q <= 1'b1;
               // mem_ready wins over a simultaneous timeout; a flush seen at any point kills the result
               if (mem_ready || timeout) begin
                  state     <= S_DONE;
                  mem_valid <= 1'b0;
                  stall     <= 1'b0;
                  if (!(kill_q || flush)) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= rd_q;
                     wb_fault <= !mem_ready;
                     wb_data  <= mem_ready ? load_val : '0;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            S_DONE: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_mem_unit.sv
// Self-checking bench for load_mem_unit: directed cases plus randomized loads against a
// reference model of the load extraction, timeout and flush rules.
module tb_load_mem_unit;
   import load_mem_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   LoadOp_t     LoadOpM;
   logic [31:0] addrM;
   logic [4:0]  rdM;
   logic        flush;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        wb_fault;
   logic        stall;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [37:0] exp_q[$];

   load_mem_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .LoadOpM(LoadOpM), .addrM(addrM), .rdM(rdM), .flush(flush),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_fault(wb_fault),
      .stall(stall), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // reference model: value a load returns from a 32-bit word
   function automatic logic [31:0] ref_extract(input LoadOp_t op, input logic [1:0] off,
                                               input logic [31:0] w);
      int unsigned b;
      int unsigned h;
      b = (w >> (8 * off)) & 32'hFF;
      h = (w >> (16 * off[1])) & 32'hFFFF;
      case (op)
         LOAD_OP_LB:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         LOAD_OP_LBU: return b;
         LOAD_OP_LH:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         LOAD_OP_LHU: return h;
         default:     return w;
      endcase
   endfunction

   function automatic bit ref_misaligned(input LoadOp_t op, input logic [1:0] off);
`ifdef LOAD_MISALIGN_TRAP_EN
      if ((op == LOAD_OP_LH || op == LOAD_OP_LHU) && off[0]) return 1'b1;
      if (op == LOAD_OP_LW && off != 2'b00) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // scoreboard check in the DONE cycle, then the following IDLE cycle
   task automatic check_done();
      bit          exp_valid;
      logic [37:0] e;
      exp_valid = (exp_q.size() > 0);
      chk("done_mem_valid", mem_valid, 0);
      chk("done_stall", stall, 0);
      chk("wb_valid", wb_valid, exp_valid);
      if (exp_valid) begin
         e = exp_q.pop_front();
         chk("wb_fault", wb_fault, e[37]);
         chk("wb_rd", wb_rd, e[36:32]);
         chk("wb_data", wb_data, e[31:0]);
      end
      @(negedge clk);
      chk("wb_one_cycle", wb_valid, 0);
      chk("idle_req_ready", req_ready, 1);
   endtask

   // driver: one load; delay>=TO means mem_ready never comes; flush_at=-2 flushes in the accept cycle
   task automatic run_load(input LoadOp_t op, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] rdata, input int delay, input int flush_at);
      int waited;
      int last;
      bit suppressed;
      bit fault;
      waited = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("req_ready_wait", req_ready, 1);
      req_valid = 1'b1;
      LoadOpM   = op;
      addrM     = addr;
      rdM       = rd;
      flush     = (flush_at == -2);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      addrM     = $urandom;
      rdM       = 5'($urandom);
      if (ref_misaligned(op, addr[1:0])) begin
         exp_q.push_back({1'b1, rd, 32'h0});
         check_done();
      end else begin
         last       = (delay < TO) ? delay : TO - 1;
         suppressed = (flush_at >= 0) && (flush_at <= last);
         fault      = (delay >= TO);
         if (!suppressed)
            exp_q.push_back({fault, rd, fault ? 32'h0 : ref_extract(op, addr[1:0], rdata)});
         for (int i = 0; i <= last; i++) begin
            chk("bus_mem_valid", mem_valid, 1);
            chk("bus_stall", stall, 1);
            chk("bus_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("bus_req_ready", req_ready, 0);
            chk("bus_wb_valid", wb_valid, 0);
            mem_ready = (i == delay);
            flush     = (i == flush_at);
            mem_rdata = (i == delay) ? rdata : $urandom;
            @(posedge clk);
            @(negedge clk);
            mem_ready = 1'b0;
            flush     = 1'b0;
         end
         check_done();
      end
   endtask

   initial begin
      LoadOp_t ops[5];
      LoadOp_t op;
      int      d;
      int      fa;
      ops = '{LOAD_OP_LB, LOAD_OP_LH, LOAD_OP_LW, LOAD_OP_LBU, LOAD_OP_LHU};
      reset = 1'b1; req_valid = 1'b0; LoadOpM = LOAD_OP_LB; addrM = '0; rdM = '0;
      flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_fault", wb_fault, 0);
      chk("rst_stall", stall, 0);
      reset = 1'b0;
      @(negedge clk);

      run_load(LOAD_OP_LB,  32'h0000_1003, 5'd7,  32'h80FF_0000, 0, -1);
      run_load(LOAD_OP_LHU, 32'h0000_2002, 5'd12, 32'hBEEF_1234, 3, -1);
      run_load(LOAD_OP_LW,  32'h0000_3000, 5'd3,  32'h1234_5678, 99, -1);
      run_load(LOAD_OP_LH,  32'h0000_4000, 5'd9,  32'h0000_8001, 2, 1);
      run_load(LOAD_OP_LW,  32'h0000_5002, 5'd21, 32'hCAFE_F00D, 1, -1);
      run_load(LOAD_OP_LH,  32'h0000_6002, 5'd4,  32'h9ABC_0000, 0, -1);
      run_load(LOAD_OP_LBU, 32'h0000_7001, 5'd31, 32'h0000_F100, 3, -1);
      run_load(LOAD_OP_LH,  32'h0000_8003, 5'd5,  32'h8123_4567, 1, -1);
      run_load(LOAD_OP_LB,  32'h0000_9000, 5'd6,  32'h0000_007F, 2, 2);
      run_load(LOAD_OP_LW,  32'h0000_A004, 5'd8,  32'hDEAD_BEEF, 0, -2);

      // asynchronous reset while the read is outstanding
      while (req_ready !== 1'b1) @(negedge clk);
      req_valid = 1'b1; LoadOpM = LOAD_OP_LW; addrM = 32'h0000_B000; rdM = 5'd2;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("pre_rst_mem_valid", mem_valid, 1);
      reset = 1'b1;
      #1;
      chk("async_rst_mem_valid", mem_valid, 0);
      chk("async_rst_stall", stall, 0);
      chk("async_rst_wb_valid", wb_valid, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", req_ready, 1);
      chk("post_rst_mem_valid", mem_valid, 0);
      chk("post_rst_wb_valid", wb_valid, 0);

      for (int n = 0; n < 40; n++) begin
         op = ops[$urandom_range(0, 4)];
         d  = $urandom_range(0, TO + 1);
         fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (d < TO) ? d : TO - 1) : -1;
         run_load(op, $urandom, 5'($urandom), $urandom, d, fa);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
